// File: rtl/wb_arbiter.sv
// Merges in-order ALU results and buffered load responses onto the single regfile write port.
// ALU results appear 1 cycle after acceptance, loads at least 2; both inputs stall only while the load FIFO is full.
module wb_arbiter #(
  parameter int LD_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_alu_valid,
  input  logic [4:0]  i_alu_rd_addr,
  input  logic [31:0] i_alu_rd_data,
  output logic        o_alu_ready,
  input  logic        i_ld_valid,
  input  logic [4:0]  i_ld_rd_addr,
  input  logic [31:0] i_ld_rd_data,
  output logic        o_ld_ready,
  output logic [37:0] o_wb_pkg,
  output logic [31:0] o_pend_mask
);

  localparam int PW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(LD_DEPTH);

  typedef struct packed {
    logic        wren;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
  } writeback_t;

  logic [4:0]    ent_addr_q [LD_DEPTH];
  logic [31:0]   ent_data_q [LD_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  writeback_t    wb_q, wb_d;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Readiness depends only on occupancy, so a pop never opens a slot in the same cycle.
  assign o_ld_ready  = ~full;
  assign o_alu_ready = ~full;

  // Loads to x0 complete the handshake but occupy no slot.
  assign push = i_ld_valid & ~full & (i_ld_rd_addr != 5'd0);

  always_comb begin
    pop  = 1'b0;
    wb_d = '0;
    if (full) begin
      pop = 1'b1;
    end else if (i_alu_valid) begin
      wb_d.wren    = (i_alu_rd_addr != 5'd0);
      wb_d.rd_addr = i_alu_rd_addr;
      wb_d.rd_data = i_alu_rd_data;
    end else if (!empty) begin
      pop = 1'b1;
    end
    if (pop) begin
      wb_d.wren    = (ent_addr_q[rd_ptr_q] != 5'd0);
      wb_d.rd_addr = ent_addr_q[rd_ptr_q];
      wb_d.rd_data = ent_data_q[rd_ptr_q];
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      wb_q     <= '0;
      for (int i = 0; i < LD_DEPTH; i++) begin
        ent_addr_q[i] <= '0;
        ent_data_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      wb_q     <= wb_d;
      if (push) begin
        ent_addr_q[wr_ptr_q] <= i_ld_rd_addr;
        ent_data_q[wr_ptr_q] <= i_ld_rd_data;
      end
    end
  end

  assign o_wb_pkg = wb_q;

  // A slot is live when its distance from the head is below the occupancy.
  logic [PW-1:0] slot_off;
  logic [31:0]   pend_mask;

  always_comb begin
    pend_mask = '0;
    slot_off  = '0;
    for (int i = 0; i < LD_DEPTH; i++) begin
      slot_off = PW'(i) - rd_ptr_q;
      if ({1'b0, slot_off} < count_q) begin
        pend_mask[ent_addr_q[i]] = 1'b1;
      end
    end
    pend_mask[0] = 1'b0;
  end

  assign o_pend_mask = pend_mask;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed vector bench for wb_arbiter: table of per-cycle inputs with expected
// ready/mask before the edge and writeback after it, plus a mid-stream reset sequence.
module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd_addr;
  logic [31:0] alu_rd_data;
  logic        alu_ready;
  logic        ld_valid;
  logic [4:0]  ld_rd_addr;
  logic [31:0] ld_rd_data;
  logic        ld_ready;
  logic [37:0] wb_pkg;
  logic [31:0] pend_mask;

  int total;
  int bad;

  wb_arbiter #(.LD_DEPTH(4)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_alu_valid  (alu_valid),
    .i_alu_rd_addr(alu_rd_addr),
    .i_alu_rd_data(alu_rd_data),
    .o_alu_ready  (alu_ready),
    .i_ld_valid   (ld_valid),
    .i_ld_rd_addr (ld_rd_addr),
    .i_ld_rd_data (ld_rd_data),
    .o_ld_ready   (ld_ready),
    .o_wb_pkg     (wb_pkg),
    .o_pend_mask  (pend_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        rdy;
    logic [31:0] mask;
    logic [37:0] wb;
  } vec_t;

  localparam int NV = 27;
  vec_t vt [NV];

  function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                              input logic lv, input logic [4:0] la, input logic [31:0] ld,
                              input logic rdy, input logic [31:0] mask, input logic [37:0] wb);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad;
    v.lv = lv; v.la = la; v.ld = ld;
    v.rdy = rdy; v.mask = mask; v.wb = wb;
    return v;
  endfunction

  function automatic logic [37:0] wbv(input logic w, input logic [4:0] a, input logic [31:0] d);
    return {w, a, d};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    alu_valid = 1'b0; alu_rd_addr = '0; alu_rd_data = '0;
    ld_valid  = 1'b0; ld_rd_addr  = '0; ld_rd_data  = '0;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    //      av aa     ad            lv la     ld            rdy mask        wb after edge
    // ALU only
    vt[0]  = mk(1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,    1, 32'h0,     wbv(1, 5'd5, 32'hDEADBEEF));
    vt[1]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    1, 32'h0,     '0);
    // load held behind streaming ALU
    vt[2]  = mk(1, 5'd1,  32'h100,      1, 5'd7,  32'h11,   1, 32'h0,     wbv(1, 5'd1, 32'h100));
    vt[3]  = mk(1, 5'd2,  32'h200,      0, 5'd0,  32'h0,    1, 32'h80,    wbv(1, 5'd2, 32'h200));
    vt[4]  = mk(1, 5'd3,  32'h300,      0, 5'd0,  32'h0,    1, 32'h80,    wbv(1, 5'd3, 32'h300));
    vt[5]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    1, 32'h80,    wbv(1, 5'd7, 32'h11));
    vt[6]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    1, 32'h0,     '0);
    // fill to full while ALU streams
    vt[7]  = mk(1, 5'd10, 32'hA0,       1, 5'd1,  32'h1001, 1, 32'h0,     wbv(1, 5'd10, 32'hA0));
    vt[8]  = mk(1, 5'd10, 32'hA1,       1, 5'd2,  32'h1002, 1, 32'h2,     wbv(1, 5'd10, 32'hA1));
    vt[9]  = mk(1, 5'd10, 32'hA2,       1, 5'd3,  32'h1003, 1, 32'h6,     wbv(1, 5'd10, 32'hA2));
    vt[10] = mk(1, 5'd10, 32'hA3,       1, 5'd4,  32'h1004, 1, 32'hE,     wbv(1, 5'd10, 32'hA3));
    vt[11] = mk(1, 5'd10, 32'hA4,       1, 5'd5,  32'h1005, 0, 32'h1E,    wbv(1, 5'd1, 32'h1001));
    vt[12] = mk(1, 5'd10, 32'hA4,       1, 5'd5,  32'h1005, 1, 32'h1C,    wbv(1, 5'd10, 32'hA4));
    vt[13] = mk(1, 5'd10, 32'hA5,       0, 5'd0,  32'h0,    0, 32'h3C,    wbv(1, 5'd2, 32'h1002));
    vt[14] = mk(1, 5'd10, 32'hA5,       0, 5'd0,  32'h0,    1, 32'h38,    wbv(1, 5'd10, 32'hA5));
    vt[15] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    1, 32'h38,    wbv(1, 5'd3, 32'h1003));
    // same-cycle push and pop at count 2
    vt[16] = mk(0, 5'd0,  32'h0,        1, 5'd6,  32'h1006, 1, 32'h30,    wbv(1, 5'd4, 32'h1004));
    vt[17] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    1, 32'h60,    wbv(1, 5'd5, 32'h1005));
    vt[18] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    1, 32'h40,    wbv(1, 5'd6, 32'h1006));
    vt[19] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    1, 32'h0,     '0);
    // x0 on both paths
    vt[20] = mk(1, 5'd0,  32'hFFFFFFFF, 1, 5'd0,  32'h55,   1, 32'h0,     wbv(0, 5'd0, 32'hFFFFFFFF));
    vt[21] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    1, 32'h0,     '0);
    // back-to-back loads: no bypass, then streaming pop/push through the wrap
    vt[22] = mk(0, 5'd0,  32'h0,        1, 5'd8,  32'h2008, 1, 32'h0,     '0);
    vt[23] = mk(0, 5'd0,  32'h0,        1, 5'd9,  32'h2009, 1, 32'h100,   wbv(1, 5'd8, 32'h2008));
    vt[24] = mk(0, 5'd0,  32'h0,        1, 5'd10, 32'h200A, 1, 32'h200,   wbv(1, 5'd9, 32'h2009));
    vt[25] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    1, 32'h400,   wbv(1, 5'd10, 32'h200A));
    vt[26] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    1, 32'h0,     '0);

    drive_idle();
    rst = 1'b1;
    #1;
    chk("reset wb_pkg",    64'(wb_pkg),    64'h0);
    chk("reset pend_mask", 64'(pend_mask), 64'h0);
    chk("reset ld_ready",  64'(ld_ready),  64'h1);
    chk("reset alu_ready", 64'(alu_ready), 64'h1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      alu_valid = vt[i].av; alu_rd_addr = vt[i].aa; alu_rd_data = vt[i].ad;
      ld_valid  = vt[i].lv; ld_rd_addr  = vt[i].la; ld_rd_data  = vt[i].ld;
      #1;
      chk($sformatf("v%0d alu_ready", i), 64'(alu_ready), 64'(vt[i].rdy));
      chk($sformatf("v%0d ld_ready", i),  64'(ld_ready),  64'(vt[i].rdy));
      chk($sformatf("v%0d pend_mask", i), 64'(pend_mask), 64'(vt[i].mask));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d wb_pkg", i), 64'(wb_pkg), 64'(vt[i].wb));
    end

    // Mid-stream reset with three loads queued behind the ALU
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      alu_valid = 1'b1; alu_rd_addr = 5'd1; alu_rd_data = 32'(k);
      ld_valid  = 1'b1; ld_rd_addr  = 5'(11 + k); ld_rd_data = 32'h3000 + 32'(k);
    end
    @(negedge clk);
    drive_idle();
    #1;
    chk("pre-reset pend_mask", 64'(pend_mask), 64'h3800);
    chk("pre-reset wb_pkg",    64'(wb_pkg),    64'(wbv(1, 5'd1, 32'h2)));
    #1;
    rst = 1'b1;
    #1;
    chk("async reset wb_pkg",    64'(wb_pkg),    64'h0);
    chk("async reset pend_mask", 64'(pend_mask), 64'h0);
    chk("async reset ld_ready",  64'(ld_ready),  64'h1);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post-reset wb_pkg c%0d", k),    64'(wb_pkg),    64'h0);
      chk($sformatf("post-reset pend_mask c%0d", k), 64'(pend_mask), 64'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
